// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arb_pkg
//  Description : Shared types and default constants for the ROM arbiter.
//                - state_t : arbiter FSM states
//                - port_t  : consumer port identifiers
//                - default SDRAM word bases and starvation limit
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PORT_SPR  = 2'd0,
        PORT_TILE = 2'd1,
        PORT_CPU  = 2'd2
    } port_t;

    localparam logic [23:0] c_cpu_base_def   = 24'h000000;
    localparam logic [23:0] c_spr_base_def   = 24'h040000;
    localparam logic [23:0] c_tile_base_def  = 24'h240000;
    localparam logic [3:0]  c_starve_max_def = 4'd15;

endpackage
`default_nettype wire

// File: rtl/rom_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arb_prio
//  Description : Combinational winner select plus CPU starvation counter.
//                Priority is spr > tile > cpu, except that the CPU wins first
//                when it is forced (cache hit) or has been passed over
//                STARVE_MAX times while waiting.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_arb_en          - arbitration allowed this cycle (FSM idle)
//                i_*_req           - consumer requests
//                i_cpu_force       - CPU must win this cycle
//                o_grant           - a winner was picked this cycle
//                o_winner          - port_t code of the winner
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_arb_prio
    import rom_arb_pkg::*;
#(
    parameter logic [3:0] STARVE_MAX = c_starve_max_def
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_arb_en,
    input  logic       i_cpu_req,
    input  logic       i_spr_req,
    input  logic       i_tile_req,
    input  logic       i_cpu_force,
    output logic       o_grant,
    output logic [1:0] o_winner
);

    logic [3:0] r_starve;
    logic       w_cpu_first;

    assign w_cpu_first = i_cpu_req && (i_cpu_force || (r_starve == STARVE_MAX));

    always_comb begin
        o_grant  = 1'b0;
        o_winner = PORT_CPU;
        if (i_arb_en) begin
            if (w_cpu_first) begin
                o_grant  = 1'b1;
                o_winner = PORT_CPU;
            end else if (i_spr_req) begin
                o_grant  = 1'b1;
                o_winner = PORT_SPR;
            end else if (i_tile_req) begin
                o_grant  = 1'b1;
                o_winner = PORT_TILE;
            end else if (i_cpu_req) begin
                o_grant  = 1'b1;
                o_winner = PORT_CPU;
            end
        end
    end

    // Counts graphics grants made while the CPU is waiting; any cycle with
    // the CPU not requesting forgets the history.
    always_ff @(posedge clk) begin
        if (rst || !i_cpu_req) begin
            r_starve <= 4'd0;
        end else if (o_grant) begin
            if (o_winner == PORT_CPU) begin
                r_starve <= 4'd0;
            end else if (r_starve < STARVE_MAX) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arbiter
//  Description : Shares one 16-bit SDRAM read port between the 68k program
//                ROM (16-bit reads) and the sprite / tile graphics ROMs
//                (32-bit reads assembled from two SDRAM words, low first).
//  Ports       : clk_main, reset   - clock, synchronous active-high reset
//                cpu_*             - 68k ROM req/addr/dout/ack
//                spr_*, tile_*     - graphics ROM req/addr/dout/ack
//                mem_*             - SDRAM read port (req held until valid)
//  Config      : ROM_ARB_CPU_CACHE_EN - one-entry CPU read cache; a hit in
//                IDLE acks the CPU next cycle without touching SDRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] CPU_BASE   = ADDR_W'(c_cpu_base_def),
    parameter logic [ADDR_W-1:0] SPR_BASE   = ADDR_W'(c_spr_base_def),
    parameter logic [ADDR_W-1:0] TILE_BASE  = ADDR_W'(c_tile_base_def),
    parameter logic [3:0]        STARVE_MAX = c_starve_max_def
) (
    input  logic              clk_main,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [17:0]       cpu_addr,
    output logic [15:0]       cpu_dout,
    output logic              cpu_ack,
    input  logic              spr_req,
    input  logic [19:0]       spr_addr,
    output logic [31:0]       spr_dout,
    output logic              spr_ack,
    input  logic              tile_req,
    input  logic [18:0]       tile_addr,
    output logic [31:0]       tile_dout,
    output logic              tile_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_din,
    input  logic              mem_valid
);

    state_t            r_state;
    state_t            w_state_nxt;
    port_t             r_port;
    logic [1:0]        w_winner;
    logic              w_grant;
    logic              w_arb_en;
    logic              w_hit;
    logic [15:0]       w_hit_data;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_req;
    logic [15:0]       r_lo;
    logic [15:0]       r_cpu_dout;
    logic [31:0]       r_spr_dout;
    logic [31:0]       r_tile_dout;
    logic              r_cpu_ack;
    logic              r_spr_ack;
    logic              r_tile_ack;

    assign w_arb_en = (r_state == IDLE);

`ifdef ROM_ARB_CPU_CACHE_EN
    logic [17:0] r_tag;
    logic        r_cache_vld;
    logic [15:0] r_cache_data;

    assign w_hit      = w_arb_en && cpu_req && r_cache_vld && (r_tag == cpu_addr);
    assign w_hit_data = r_cache_data;

    // cpu_addr is still held by the requester while its SDRAM beat completes.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            r_cache_vld  <= 1'b0;
            r_tag        <= '0;
            r_cache_data <= '0;
        end else if (r_state == BEAT0 && mem_valid && r_port == PORT_CPU) begin
            r_cache_vld  <= 1'b1;
            r_tag        <= cpu_addr;
            r_cache_data <= mem_din;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 16'h0000;
`endif

    rom_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk         (clk_main),
        .rst         (reset),
        .i_arb_en    (w_arb_en),
        .i_cpu_req   (cpu_req),
        .i_spr_req   (spr_req),
        .i_tile_req  (tile_req),
        .i_cpu_force (w_hit),
        .o_grant     (w_grant),
        .o_winner    (w_winner)
    );

    // Graphics addresses are 32-bit word addresses: two SDRAM words each.
    always_comb begin
        w_addr = CPU_BASE + ADDR_W'(cpu_addr);
        if (w_winner == PORT_SPR) begin
            w_addr = SPR_BASE + ADDR_W'({spr_addr, 1'b0});
        end else if (w_winner == PORT_TILE) begin
            w_addr = TILE_BASE + ADDR_W'({tile_addr, 1'b0});
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_nxt = DONE;
                end else if (w_grant) begin
                    w_state_nxt = BEAT0;
                end
            end
            BEAT0: begin
                if (mem_valid) begin
                    w_state_nxt = (r_port == PORT_CPU) ? DONE : BEAT1;
                end
            end
            BEAT1: begin
                if (mem_valid) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_main) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Acks and douts are registered on the transition into DONE so that both
    // appear together in the DONE cycle.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            r_port      <= PORT_CPU;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_lo        <= '0;
            r_cpu_dout  <= '0;
            r_spr_dout  <= '0;
            r_tile_dout <= '0;
            r_cpu_ack   <= 1'b0;
            r_spr_ack   <= 1'b0;
            r_tile_ack  <= 1'b0;
        end else begin
            r_cpu_ack  <= 1'b0;
            r_spr_ack  <= 1'b0;
            r_tile_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_port <= port_t'(w_winner);
                        if (w_hit) begin
                            r_cpu_ack  <= 1'b1;
                            r_cpu_dout <= w_hit_data;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_addr;
                        end
                    end
                end
                BEAT0: begin
                    if (mem_valid) begin
                        r_lo <= mem_din;
                        if (r_port == PORT_CPU) begin
                            r_mem_req  <= 1'b0;
                            r_cpu_ack  <= 1'b1;
                            r_cpu_dout <= mem_din;
                        end else begin
                            // mem_req stays high; only the address advances.
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        end
                    end
                end
                BEAT1: begin
                    if (mem_valid) begin
                        r_mem_req <= 1'b0;
                        if (r_port == PORT_SPR) begin
                            r_spr_ack  <= 1'b1;
                            r_spr_dout <= {mem_din, r_lo};
                        end else begin
                            r_tile_ack  <= 1'b1;
                            r_tile_dout <= {mem_din, r_lo};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign cpu_dout  = r_cpu_dout;
    assign cpu_ack   = r_cpu_ack;
    assign spr_dout  = r_spr_dout;
    assign spr_ack   = r_spr_ack;
    assign tile_dout = r_tile_dout;
    assign tile_ack  = r_tile_ack;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_arbiter
//  Description : Self-checking bench for rom_arbiter. Table-driven single
//                reads, hand sequences for arbitration/starvation/reset/cache,
//                then random traffic checked against a memory-content model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    localparam int P_SPR  = 0;
    localparam int P_TILE = 1;
    localparam int P_CPU  = 2;

    logic        clk_main = 1'b0;
    logic        reset;
    logic        cpu_req, spr_req, tile_req;
    logic [17:0] cpu_addr;
    logic [19:0] spr_addr;
    logic [18:0] tile_addr;
    logic [15:0] cpu_dout;
    logic [31:0] spr_dout, tile_dout;
    logic        cpu_ack, spr_ack, tile_ack;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int lat_cfg = 0;   // -1: random latency per beat

    rom_arbiter dut (
        .clk_main  (clk_main),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .spr_req   (spr_req),
        .spr_addr  (spr_addr),
        .spr_dout  (spr_dout),
        .spr_ack   (spr_ack),
        .tile_req  (tile_req),
        .tile_addr (tile_addr),
        .tile_dout (tile_dout),
        .tile_ack  (tile_ack),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_valid (mem_valid)
    );

    always #5 clk_main = ~clk_main;

    // SDRAM contents.
    function automatic logic [15:0] mem_word(input logic [23:0] a);
        case (a)
            24'h000010: return 16'hBEEF;
            24'h040006: return 16'h1111;
            24'h040007: return 16'h2222;
            default:    return (a[15:0] ^ {a[23:16], a[23:16]}) + 16'h1357;
        endcase
    endfunction

    // Expected read result from the address map.
    function automatic logic [31:0] exp_data(input int p, input logic [19:0] a);
        logic [23:0] b;
        if (p == P_CPU) begin
            return {16'h0000, mem_word(24'h000000 + {6'd0, a[17:0]})};
        end
        if (p == P_SPR) b = 24'h040000 + {3'd0, a, 1'b0};
        else            b = 24'h240000 + {4'd0, a[18:0], 1'b0};
        return {mem_word(b + 24'd1), mem_word(b)};
    endfunction

    // SDRAM responder: mem_valid L cycles after each new (req, addr) beat.
    initial begin : responder
        int          cnt;
        int          cur_lat;
        logic        served;
        logic        prev_req;
        logic [23:0] prev_addr;
        mem_valid = 1'b0;
        mem_din   = 16'hDEAD;
        cnt = 0; cur_lat = 0; served = 1'b0; prev_req = 1'b0; prev_addr = '0;
        forever begin
            @(posedge clk_main); #1;
            if (mem_req) begin
                if (!prev_req || mem_addr != prev_addr) begin
                    cnt     = 0;
                    served  = 1'b0;
                    cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
                end
                if (!served && cnt == cur_lat) begin
                    mem_valid = 1'b1;
                    mem_din   = mem_word(mem_addr);
                    served    = 1'b1;
                end else begin
                    mem_valid = 1'b0;
                    mem_din   = 16'hDEAD;
                end
                cnt++;
            end else begin
                mem_valid = 1'b0;
                mem_din   = 16'hDEAD;
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [19:0] a);
        case (p)
            P_CPU:   begin cpu_req  = v; cpu_addr  = a[17:0]; end
            P_SPR:   begin spr_req  = v; spr_addr  = a;       end
            default: begin tile_req = v; tile_addr = a[18:0]; end
        endcase
    endtask

    function automatic logic ack_of(input int p);
        return (p == P_CPU) ? cpu_ack : (p == P_SPR) ? spr_ack : tile_ack;
    endfunction

    function automatic logic req_of(input int p);
        return (p == P_CPU) ? cpu_req : (p == P_SPR) ? spr_req : tile_req;
    endfunction

    function automatic logic [31:0] dout_of(input int p);
        return (p == P_CPU) ? {16'h0000, cpu_dout} : (p == P_SPR) ? spr_dout : tile_dout;
    endfunction

    task automatic apply_reset();
        @(posedge clk_main); #1;
        reset = 1'b1;
        cpu_req = 1'b0; spr_req = 1'b0; tile_req = 1'b0;
        repeat (2) @(posedge clk_main);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic [19:0] addr;
        int          lat;
        logic [31:0] exp_d;
        logic [23:0] exp_a0;
        int          exp_ack;
    } vec_t;

    // One isolated read; cycle 0 is the cycle in which the request is sampled.
    task automatic run_vec(input vec_t v);
        int          ack_c;
        logic        seen;
        logic [23:0] a_first, a_last;
        logic [31:0] d;
        ack_c = -1; seen = 1'b0; a_first = '0; a_last = '0; d = '0;
        lat_cfg = v.lat;
        @(posedge clk_main); #1;
        set_req(v.port, 1'b1, v.addr);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk_main); #1;
            if (mem_req) begin
                if (!seen) a_first = mem_addr;
                seen   = 1'b1;
                a_last = mem_addr;
            end
            if (ack_of(v.port)) begin
                ack_c = c;
                d     = dout_of(v.port);
                set_req(v.port, 1'b0, v.addr);
                break;
            end
        end
        if (ack_c < 0) set_req(v.port, 1'b0, v.addr);
        check($sformatf("vec p%0d ack_cycle", v.port), ack_c, v.exp_ack);
        check($sformatf("vec p%0d dout", v.port), d, v.exp_d);
        check($sformatf("vec p%0d addr0", v.port), {8'd0, a_first}, {8'd0, v.exp_a0});
        check($sformatf("vec p%0d addr_last", v.port), {8'd0, a_last},
              {8'd0, (v.port == P_CPU) ? v.exp_a0 : v.exp_a0 + 24'd1});
        @(posedge clk_main); #1;
        check($sformatf("vec p%0d ack_one_cycle", v.port), {31'd0, ack_of(v.port)}, 32'd0);
    endtask

    initial begin : main
        vec_t vecs[6];
        int   order[$];
        int   nack[3];
        int   nspr;
        logic got, found, tile_seen;
        logic [19:0] raddr[3];
        int   waitc[3];
        int   starve;
        int   nacks;

        reset = 1'b1;
        cpu_req = 1'b0; spr_req = 1'b0; tile_req = 1'b0;
        cpu_addr = '0; spr_addr = '0; tile_addr = '0;
        repeat (3) @(posedge clk_main);
        #1;
        check("reset mem_req",   {31'd0, mem_req}, 0);
        check("reset mem_addr",  {8'd0, mem_addr}, 0);
        check("reset acks",      {29'd0, cpu_ack, spr_ack, tile_ack}, 0);
        check("reset cpu_dout",  {16'd0, cpu_dout}, 0);
        check("reset spr_dout",  spr_dout, 0);
        check("reset tile_dout", tile_dout, 0);
        reset = 1'b0;

        // ---------------- table-driven single reads ----------------
        vecs[0] = '{P_CPU,  20'h00010, 2, 32'h0000_BEEF,              24'h000010, 4};
        vecs[1] = '{P_SPR,  20'h00003, 0, 32'h2222_1111,              24'h040006, 3};
        vecs[2] = '{P_TILE, 20'h00005, 1, exp_data(P_TILE, 20'h00005), 24'h24000A, 5};
        vecs[3] = '{P_CPU,  20'h3FFFF, 0, exp_data(P_CPU, 20'h3FFFF),  24'h03FFFF, 2};
        vecs[4] = '{P_SPR,  20'hFFFFF, 1, exp_data(P_SPR, 20'hFFFFF),  24'h23FFFE, 5};
        vecs[5] = '{P_TILE, 20'h7FFFF, 3, exp_data(P_TILE, 20'h7FFFF), 24'h33FFFE, 9};
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            run_vec(vecs[i]);
        end

        // ---------------- simultaneous requests ----------------
        apply_reset();
        lat_cfg = 0;
        nack = '{0, 0, 0};
        @(posedge clk_main); #1;
        set_req(P_SPR, 1'b1, 20'h00011);
        set_req(P_TILE, 1'b1, 20'h00022);
        set_req(P_CPU, 1'b1, 20'h00033);
        for (int c = 0; c < 60; c++) begin
            @(posedge clk_main); #1;
            for (int p = 0; p < 3; p++) begin
                if (ack_of(p)) begin
                    nack[p]++;
                    order.push_back(p);
                    set_req(p, 1'b0, 20'h0);
                end
            end
        end
        check("simul order0", (order.size() > 0) ? order[0] : -1, P_SPR);
        check("simul order1", (order.size() > 1) ? order[1] : -1, P_TILE);
        check("simul order2", (order.size() > 2) ? order[2] : -1, P_CPU);
        check("simul spr acks",  nack[P_SPR], 1);
        check("simul tile acks", nack[P_TILE], 1);
        check("simul cpu acks",  nack[P_CPU], 1);

        // ---------------- CPU starvation ----------------
        apply_reset();
        lat_cfg = 0;
        nspr = 0; got = 1'b0;
        @(posedge clk_main); #1;
        set_req(P_CPU, 1'b1, 20'h00005);
        set_req(P_SPR, 1'b1, 20'h00100);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_main); #1;
            if (spr_ack) begin
                nspr++;
                spr_req = 1'b0;
            end else if (!spr_req) begin
                spr_req = 1'b1;
            end
            if (cpu_ack) begin
                got = 1'b1;
                cpu_req = 1'b0;
                break;
            end
        end
        check("starve cpu granted", {31'd0, got}, 1);
        check("starve spr grants before cpu", nspr, 15);
        check("starve cpu data", {16'd0, cpu_dout}, exp_data(P_CPU, 20'h00005));

        // ---------------- reset during BEAT1 of a tile read ----------------
        apply_reset();
        lat_cfg = 3;
        found = 1'b0; tile_seen = 1'b0;
        @(posedge clk_main); #1;
        set_req(P_TILE, 1'b1, 20'h00009);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_main); #1;
            if (tile_ack) tile_seen = 1'b1;
            if (mem_req && mem_addr == 24'h240013) begin
                found = 1'b1;
                break;
            end
        end
        check("rst reached beat1", {31'd0, found}, 1);
        reset = 1'b1;
        tile_req = 1'b0;
        @(posedge clk_main); #1;
        check("rst mem_req dropped", {31'd0, mem_req}, 0);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_main); #1;
            if (tile_ack) tile_seen = 1'b1;
        end
        check("rst no tile_ack", {31'd0, tile_seen}, 0);
        run_vec('{P_CPU, 20'h00040, 1, exp_data(P_CPU, 20'h00040), 24'h000040, 3});

`ifdef ROM_ARB_CPU_CACHE_EN
        // ---------------- CPU cache hit ----------------
        apply_reset();
        run_vec('{P_CPU, 20'h00020, 2, exp_data(P_CPU, 20'h00020), 24'h000020, 4});
        lat_cfg = 1;
        @(posedge clk_main); #1;
        set_req(P_CPU, 1'b1, 20'h00020);
        set_req(P_SPR, 1'b1, 20'h00077);
        @(posedge clk_main); #1;
        check("cache hit ack cycle1", {31'd0, cpu_ack}, 1);
        check("cache hit no mem_req", {31'd0, mem_req}, 0);
        check("cache hit data", {16'd0, cpu_dout}, exp_data(P_CPU, 20'h00020));
        cpu_req = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_main); #1;
            if (spr_ack) begin
                got = 1'b1;
                spr_req = 1'b0;
                check("cache spr after hit", spr_dout, exp_data(P_SPR, 20'h00077));
                break;
            end
        end
        check("cache spr completed", {31'd0, got}, 1);
`endif

        // ---------------- random traffic vs. memory model ----------------
        apply_reset();
        lat_cfg = -1;
        waitc  = '{0, 0, 0};
        raddr  = '{20'h0, 20'h0, 20'h0};
        starve = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk_main); #1;
            nacks = int'(cpu_ack) + int'(spr_ack) + int'(tile_ack);
            if (nacks > 1) check("rnd ack onehot", nacks, 1);
            for (int p = 0; p < 3; p++) begin
                if (ack_of(p)) begin
                    check($sformatf("rnd p%0d ack with req", p), {31'd0, req_of(p)}, 1);
                    check($sformatf("rnd p%0d data a=%0h", p, raddr[p]), dout_of(p), exp_data(p, raddr[p]));
                    if (p == P_CPU) begin
                        // One graphics grant may predate the CPU request.
                        if (starve > 16) check("rnd cpu starvation", starve, 16);
                        starve = 0;
                    end else if (cpu_req) begin
                        starve++;
                    end
                    set_req(p, 1'b0, raddr[p]);
                    waitc[p] = 0;
                end else if (req_of(p)) begin
                    waitc[p]++;
                    if (waitc[p] > 400) begin
                        check($sformatf("rnd p%0d timeout", p), waitc[p], 400);
                        set_req(p, 1'b0, raddr[p]);
                        waitc[p] = 0;
                        if (p == P_CPU) starve = 0;
                    end
                end else if (cyc < 3600 && $urandom_range(0, 3) == 0) begin
                    if (p == P_CPU) raddr[p] = 20'($urandom_range(0, 7));
                    else            raddr[p] = 20'($urandom);
                    if (p == P_TILE) raddr[p][19] = 1'b0;
                    if (p == P_CPU && $urandom_range(0, 1) == 1) raddr[p] = 20'($urandom) & 20'h3FFFF;
                    set_req(p, 1'b1, raddr[p]);
                    waitc[p] = 0;
                end
            end
        end
        check("rnd drained", {29'd0, cpu_req, spr_req, tile_req}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
